// File: rtl/crc_dec_pkg.sv
// Shared definitions for the CRC decelerator pin protocol and its host-side sequencer.
package crc_dec_pkg;

  localparam int unsigned BITWIDTH = 32;
  localparam int unsigned BITBITS  = $clog2(BITWIDTH);

  localparam logic [1:0] CMD_RESET   = 2'd0;
  localparam logic [1:0] CMD_SETUP   = 2'd1;
  localparam logic [1:0] CMD_MESSAGE = 2'd2;
  localparam logic [1:0] CMD_FINAL   = 2'd3;

  // Bit positions inside the second configuration nibble.
  localparam int unsigned CFG_HI_REFLECT_IN  = 0;
  localparam int unsigned CFG_HI_REFLECT_OUT = 1;
  localparam int unsigned CFG_HI_WIDTH4      = 2;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StCfgLo,
    StCfgHi,
    StPoly,
    StInit,
    StXor,
    StTail,
    StLead,
    StSlot,
    StHi,
    StGap,
    StDone
  } seq_state_e;

  function automatic logic [2:0] nibble_count(input logic [4:0] width);
    return width[4:2];
  endfunction

endpackage

// File: rtl/crc_field_serializer.sv
// Emits a config word as N nibbles, least-significant first; reloaded once per field.
module crc_field_serializer #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [BITWIDTH-1:0] word_i,
  input  logic [2:0]          n_i,
  input  logic                adv_i,
  output logic [3:0]          nibble_o,
  output logic                last_o
);

  logic [BITWIDTH-1:0] word_q, word_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          n_q, n_d;

  assign nibble_o = word_q[3:0];
  assign last_o   = (cnt_q == n_q - 3'd1);

  // A load wins over an advance so the next field can follow its predecessor's last nibble.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    n_d    = n_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = 3'd0;
      n_d    = n_i;
    end else if (adv_i) begin
      word_d = word_q >> 4;
      cnt_d  = last_o ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= 3'd0;
      n_q    <= 3'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
    end
  end

endmodule

// File: rtl/crc_nibble_sequencer.sv
// Serialises a CRC configuration and a byte stream onto the decelerator's cmd/data pins,
// open-loop against the decelerator's fixed setup and per-byte shift latencies.
module crc_nibble_sequencer #(
  parameter int unsigned BITWIDTH   = 32,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          cfg_width,
  input  logic                cfg_reflect_in,
  input  logic                cfg_reflect_out,
  input  logic [BITWIDTH-1:0] cfg_poly,
  input  logic [BITWIDTH-1:0] cfg_init,
  input  logic [BITWIDTH-1:0] cfg_xor,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic [1:0]          io_cmd,
  output logic [3:0]          io_data,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  import crc_dec_pkg::*;

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_e          state_q, state_d;
  logic [4:0]          width_q, width_d;
  logic                refl_in_q, refl_in_d;
  logic                refl_out_q, refl_out_d;
  logic [BITWIDTH-1:0] poly_q, poly_d;
  logic [BITWIDTH-1:0] init_q, init_d;
  logic [BITWIDTH-1:0] xor_q, xor_d;
  logic                last_q, last_d;
  logic                fld_end_q, fld_end_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]          io_cmd_q, io_cmd_d;
  logic [3:0]          io_data_q, io_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic                ser_load, ser_adv, ser_last;
  logic [BITWIDTH-1:0] ser_word;
  logic [3:0]          ser_nib;
  logic [3:0]          cfg_hi;

  crc_field_serializer #(
    .BITWIDTH(BITWIDTH)
  ) u_field_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .n_i     (nibble_count(width_q)),
    .adv_i   (ser_adv),
    .nibble_o(ser_nib),
    .last_o  (ser_last)
  );

  always_comb begin
    cfg_hi                     = 4'd0;
    cfg_hi[CFG_HI_REFLECT_IN]  = refl_in_q;
    cfg_hi[CFG_HI_REFLECT_OUT] = refl_out_q;
    cfg_hi[CFG_HI_WIDTH4]      = width_q[4];
  end

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    refl_in_d  = refl_in_q;
    refl_out_d = refl_out_q;
    poly_d     = poly_q;
    init_d     = init_q;
    xor_d      = xor_q;
    last_d     = last_q;
    fld_end_d  = fld_end_q;
    gap_cnt_d  = gap_cnt_q;
    io_data_d  = 4'd0;
    cfg_err_d  = 1'b0;
    ser_load   = 1'b0;
    ser_adv    = 1'b0;
    ser_word   = poly_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (nibble_count(cfg_width) == 3'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            width_d    = cfg_width;
            refl_in_d  = cfg_reflect_in;
            refl_out_d = cfg_reflect_out;
            poly_d     = cfg_poly;
            init_d     = cfg_init;
            xor_d      = cfg_xor;
            state_d    = StHdr;
          end
        end
      end
      StHdr: begin
        state_d   = StCfgLo;
        io_data_d = width_q[3:0];
        ser_load  = 1'b1;
        fld_end_d = 1'b0;
      end
      StCfgLo: begin
        state_d   = StCfgHi;
        io_data_d = cfg_hi;
      end
      // Outputs are registered, so each cycle here picks the nibble shown next cycle.
      StCfgHi, StPoly, StInit, StXor: begin
        if (state_q == StCfgHi) begin
          state_d = StPoly;
        end else if (fld_end_q) begin
          state_d = (state_q == StPoly) ? StInit : (state_q == StInit) ? StXor : StTail;
        end
        if (state_d != StTail) begin
          ser_adv   = 1'b1;
          io_data_d = ser_nib;
          fld_end_d = ser_last;
          if (ser_last && state_d != StXor) begin
            ser_load = 1'b1;
            ser_word = (state_d == StPoly) ? init_q : xor_q;
          end
        end
      end
      StTail: state_d = StLead;
      StLead: state_d = StSlot;
      StSlot: begin
        if (s_valid) begin
          state_d   = StHi;
          io_data_d = s_data[7:4];
          last_d    = s_last;
        end
      end
      StHi: begin
        state_d   = StGap;
        gap_cnt_d = '0;
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = last_q ? StDone : StSlot;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StIdle:                                          io_cmd_d = CMD_RESET;
      StHdr, StCfgLo, StCfgHi, StPoly, StInit, StXor, StTail: io_cmd_d = CMD_SETUP;
      StLead, StHi, StGap:                             io_cmd_d = CMD_MESSAGE;
      default:                                         io_cmd_d = CMD_FINAL;
    endcase
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      width_q    <= 5'd0;
      refl_in_q  <= 1'b0;
      refl_out_q <= 1'b0;
      poly_q     <= '0;
      init_q     <= '0;
      xor_q      <= '0;
      last_q     <= 1'b0;
      fld_end_q  <= 1'b0;
      gap_cnt_q  <= '0;
      io_cmd_q   <= CMD_RESET;
      io_data_q  <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      refl_in_q  <= refl_in_d;
      refl_out_q <= refl_out_d;
      poly_q     <= poly_d;
      init_q     <= init_d;
      xor_q      <= xor_d;
      last_q     <= last_d;
      fld_end_q  <= fld_end_d;
      gap_cnt_q  <= gap_cnt_d;
      io_cmd_q   <= io_cmd_d;
      io_data_q  <= io_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // In SLOT the pins follow s_valid directly: low nibble when a byte is offered, else hold.
  assign s_ready = (state_q == StSlot);
  assign io_cmd  = s_ready ? (s_valid ? CMD_MESSAGE : CMD_FINAL) : io_cmd_q;
  assign io_data = s_ready ? (s_valid ? s_data[3:0] : 4'd0) : io_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_crc_nibble_sequencer.sv
// Bench for crc_nibble_sequencer: queue-based pin-stream model plus directed literal checks.
module tb_crc_nibble_sequencer;

  localparam int unsigned BW  = 32;
  localparam int unsigned GAP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4:0]    cfg_width;
  logic          cfg_reflect_in, cfg_reflect_out;
  logic [BW-1:0] cfg_poly, cfg_init, cfg_xor;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic [1:0]    io_cmd;
  logic [3:0]    io_data;
  logic          busy, done, cfg_err;

  int tests = 0;
  int fails = 0;

  crc_nibble_sequencer #(
    .BITWIDTH  (BW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_width      (cfg_width),
    .cfg_reflect_in (cfg_reflect_in),
    .cfg_reflect_out(cfg_reflect_out),
    .cfg_poly       (cfg_poly),
    .cfg_init       (cfg_init),
    .cfg_xor        (cfg_xor),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .io_cmd         (io_cmd),
    .io_data        (io_data),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: expected pin beats as a queue ----------------
  typedef struct packed {
    logic [1:0] cmd;
    logic [3:0] data;
  } beat_t;

  localparam int PIdle = 0, PSlot = 1, PDone = 2;

  beat_t mq[$];
  int    ph        = PIdle;
  bit    mvalid    = 1'b0;
  bit    err_exp   = 1'b0;
  bit    last_pend = 1'b0;

  function automatic beat_t mk(input logic [1:0] c, input logic [3:0] d);
    beat_t b;
    b.cmd  = c;
    b.data = d;
    return b;
  endfunction

  task automatic push_field(input logic [BW-1:0] f, input int n);
    for (int i = 0; i < n; i++) mq.push_back(mk(2'd1, 4'((f >> (4 * i)) & 32'hF)));
  endtask

  task automatic push_setup();
    int n;
    n = int'(cfg_width) / 4;
    mq.push_back(mk(2'd1, 4'd0));
    mq.push_back(mk(2'd1, cfg_width[3:0]));
    mq.push_back(mk(2'd1, {1'b0, cfg_width[4], cfg_reflect_out, cfg_reflect_in}));
    push_field(cfg_poly, n);
    push_field(cfg_init, n);
    push_field(cfg_xor, n);
    mq.push_back(mk(2'd1, 4'd0));
    mq.push_back(mk(2'd2, 4'd0));
  endtask

  initial begin : compare
    logic [1:0] ec;
    logic [3:0] ed;
    bit         eb, edn, er, err_n;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        if (mq.size() > 0) begin
          ec = mq[0].cmd; ed = mq[0].data; eb = 1; edn = 0; er = 0;
        end else if (ph == PSlot) begin
          ec = s_valid ? 2'd2 : 2'd3; ed = s_valid ? s_data[3:0] : 4'd0;
          eb = 1; edn = 0; er = 1;
        end else if (ph == PDone) begin
          ec = 2'd3; ed = 4'd0; eb = 0; edn = 1; er = 0;
        end else begin
          ec = 2'd0; ed = 4'd0; eb = 0; edn = 0; er = 0;
        end
        check("cmd", 32'(io_cmd), 32'(ec));
        check("data", 32'(io_data), 32'(ed));
        check("busy", 32'(busy), 32'(eb));
        check("done", 32'(done), 32'(edn));
        check("s_ready", 32'(s_ready), 32'(er));
        check("cfg_err", 32'(cfg_err), 32'(err_exp));
      end
      if (rst) begin
        mq.delete();
        ph = PIdle; err_exp = 0; last_pend = 0; mvalid = 1;
      end else if (mvalid) begin
        err_n = 0;
        if (mq.size() > 0) begin
          void'(mq.pop_front());
          if (mq.size() == 0) ph = last_pend ? PDone : PSlot;
        end else if (ph == PSlot) begin
          if (s_valid) begin
            mq.push_back(mk(2'd2, s_data[7:4]));
            for (int i = 0; i < GAP; i++) mq.push_back(mk(2'd2, 4'd0));
            last_pend = s_last;
          end
        end else if (start) begin
          if (cfg_width < 5'd4) err_n = 1;
          else begin
            push_setup();
            last_pend = 0;
          end
        end
        err_exp = err_n;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [4:0] w, input logic ri, input logic ro,
                         input logic [BW-1:0] p, input logic [BW-1:0] i, input logic [BW-1:0] x);
    cfg_width = w; cfg_reflect_in = ri; cfg_reflect_out = ro;
    cfg_poly = p; cfg_init = i; cfg_xor = x;
  endtask

  task automatic stream(input int nbytes, input int stall_pct, input bit rand_start);
    int sent;
    int cyc;
    bit acc, fin;
    sent = 0; cyc = 0; fin = 0;
    s_data = 8'($urandom); s_last = (nbytes == 1); s_valid = 1;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      fin = done;
      step();
      cyc++;
      start = 0;
      if (acc) begin sent++; s_data = 8'($urandom); end
      if (sent < nbytes) begin
        s_valid = ($urandom_range(99) >= stall_pct);
        s_last  = (sent == nbytes - 1);
      end else begin
        s_valid = 0; s_last = 0;
      end
      if (rand_start && sent < nbytes && $urandom_range(7) == 0) begin
        start = 1; cfg_width = 5'($urandom);
      end
    end
    check("stream_done", 32'(fin), 32'd1);
  endtask

  initial begin : driver
    logic [3:0] tab [16];
    bit acc, fin;
    int stalls, phase, cnt;
    logic [4:0] w;

    tab = '{4'h0, 4'h0, 4'h4, 4'h1, 4'h2, 4'h0, 4'h1, 4'hF,
            4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst = 1; start = 0; s_valid = 0; s_data = 0; s_last = 0;
    set_cfg(5'd0, 0, 0, '0, '0, '0);
    repeat (2) step();
    @(negedge clk);
    check("rst_cmd", 32'(io_cmd), 32'd0);
    check("rst_data", 32'(io_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    step();
    rst = 0;

    // CRC-16/CCITT-FALSE config, message "12", always valid.
    set_cfg(5'b10000, 0, 0, 32'h1021, 32'hFFFF, 32'h0);
    start = 1; s_valid = 1; s_data = 8'h31; s_last = 0;
    step();
    start = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        check("crc16_setup_cmd", 32'(io_cmd), 32'd1);
        check("crc16_setup_data", 32'(io_data), 32'(tab[k-1]));
      end
      if (k == 17) check("crc16_lead_cmd", 32'(io_cmd), 32'd2);
      if (k == 18) check("crc16_b0_lo", 32'(io_data), 32'h1);
      if (k == 19) check("crc16_b0_hi", 32'(io_data), 32'h3);
      if (k == 27) check("crc16_gap_end", {26'd0, io_cmd, io_data}, 32'h20);
      if (k == 28) check("crc16_b1_lo", 32'(io_data), 32'h2);
      if (k == 29) check("crc16_b1_hi", 32'(io_data), 32'h3);
      if (k == 37) check("crc16_not_done_yet", 32'(done), 32'd0);
      if (k == 38) begin
        check("crc16_final_cmd", 32'(io_cmd), 32'd3);
        check("crc16_done", 32'(done), 32'd1);
      end
      acc = s_valid && s_ready;
      step();
      if (acc) begin
        if (s_last) s_valid = 0;
        else begin s_data = 8'h32; s_last = 1; end
      end
    end

    // Five-cycle stall at the second SLOT.
    start = 1; s_valid = 1; s_data = 8'hA5; s_last = 0;
    step();
    start = 0; stalls = 0; phase = 0; fin = 0;
    for (int k = 1; k <= 100 && !fin; k++) begin
      @(negedge clk);
      if (phase == 1 && s_ready) begin
        check("stall_cmd", 32'(io_cmd), 32'd3);
        check("stall_data", 32'(io_data), 32'd0);
        stalls++;
      end
      if (phase == 2 && s_ready) begin
        check("stall_release", {26'd0, io_cmd, io_data}, 32'h2A);
      end
      acc = s_valid && s_ready;
      fin = done;
      step();
      if (phase == 0 && acc) begin s_valid = 0; phase = 1; end
      else if (phase == 1 && stalls == 5) begin
        s_valid = 1; s_data = 8'h5A; s_last = 1; phase = 2;
      end else if (phase == 2 && acc) begin s_valid = 0; phase = 3; end
    end
    check("stall_finished", 32'(fin), 32'd1);

    // Rejected start from IDLE.
    rst = 1;
    step();
    rst = 0;
    cfg_width = 5'b00011; start = 1;
    step();
    start = 0;
    @(negedge clk);
    check("err_pulse", 32'(cfg_err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_cmd", 32'(io_cmd), 32'd0);
    step();
    @(negedge clk);
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    step();

    // Reset during POLY, then a clean rerun.
    set_cfg(5'b10000, 0, 0, 32'h1021, 32'hFFFF, 32'h0);
    start = 1; s_valid = 0;
    step();
    start = 0;
    repeat (4) step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("abort_cmd", 32'(io_cmd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    start = 1;
    step();
    start = 0;
    stream(2, 20, 1);

    // Restart from DONE with the widest code: 7 nibbles per field.
    set_cfg(5'b11111, 1, 0, 32'h0765_4321, 32'h0FED_CBA9, 32'h0AAA_5555);
    start = 1; s_valid = 0;
    step();
    start = 0; cnt = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (io_cmd == 2'd1) cnt++;
      if (k == 3) check("w31_cfg_hi", 32'(io_data), 32'h5);
      if (k >= 4 && k <= 10) check("w31_poly_nib", 32'(io_data), 32'(k - 3));
      if (k == 26) check("w31_lead", 32'(io_cmd), 32'd2);
      step();
    end
    check("w31_setup_len", 32'(cnt), 32'd25);
    stream(1, 0, 0);

    // Randomised transactions.
    for (int t = 0; t < 14; t++) begin
      w = 5'($urandom);
      set_cfg(w, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      start = 1; s_valid = 0;
      step();
      start = 0;
      if (w[4:2] == 3'd0) repeat (3) step();
      else stream(int'($urandom_range(1, 4)), int'($urandom_range(0, 50)), 1);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
